// File: rtl/mage_pkg.sv
// Shared sizing constants and FSM encoding for the hardware-loop IV generator.
package mage_pkg;

    localparam int N_LP              = 4;
    localparam int NBIT_LP_IV        = 8;
    localparam int HWLP_RF_SIZE      = 8;
    localparam int LOG2_N_LP         = $clog2(N_LP);
    localparam int LOG2_HWLP_RF_SIZE = $clog2(HWLP_RF_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } hwlp_ivgen_state_e;

endpackage

// File: rtl/hwlp_iv_counter.sv
// One loop level: holds its captured start/end/stride and steps its IV when
// every inner loop wraps (carry_i); wrap_o reports that the next step wraps.
module hwlp_iv_counter #(
    parameter int NBIT_LP_IV = mage_pkg::NBIT_LP_IV
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic                  active_i,
    input  logic [NBIT_LP_IV-1:0] start_val_i,
    input  logic [NBIT_LP_IV-1:0] end_val_i,
    input  logic [NBIT_LP_IV-1:0] stride_i,
    input  logic                  step_i,
    input  logic                  carry_i,
    output logic [NBIT_LP_IV-1:0] iv_o,
    output logic                  active_o,
    output logic                  at_start_o,
    output logic                  wrap_o,
    output logic                  carry_o
);

    logic [NBIT_LP_IV-1:0] iv_q;
    logic [NBIT_LP_IV-1:0] start_q;
    logic [NBIT_LP_IV-1:0] end_q;
    logic [NBIT_LP_IV-1:0] stride_q;
    logic                  active_q;
    logic [NBIT_LP_IV:0]   sum;

    // The extra sum bit keeps iv+stride from aliasing below end on overflow.
    assign sum        = {1'b0, iv_q} + {1'b0, stride_q};
    assign wrap_o     = sum > {1'b0, end_q};
    assign carry_o    = carry_i & wrap_o;
    assign at_start_o = (iv_q == start_q);
    assign iv_o       = iv_q;
    assign active_o   = active_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            iv_q     <= '0;
            start_q  <= '0;
            end_q    <= '0;
            stride_q <= '0;
            active_q <= 1'b0;
        end else if (load_i) begin
            active_q <= active_i;
            start_q  <= active_i ? start_val_i : '0;
            end_q    <= end_val_i;
            stride_q <= (stride_i == '0) ? {{(NBIT_LP_IV-1){1'b0}}, 1'b1} : stride_i;
            iv_q     <= active_i ? start_val_i : '0;
        end else if (step_i && carry_i && active_q) begin
            iv_q <= wrap_o ? start_q : sum[NBIT_LP_IV-1:0];
        end
    end

endmodule

// File: rtl/hwlp_ivgen.sv
// Hardware-loop induction-variable generator: walks an N_LP-deep loop nest and
// pushes one IV tuple per cycle into a shifting register file of HWLP_RF_SIZE entries.
module hwlp_ivgen #(
    parameter int N_LP         = mage_pkg::N_LP,
    parameter int NBIT_LP_IV   = mage_pkg::NBIT_LP_IV,
    parameter int HWLP_RF_SIZE = mage_pkg::HWLP_RF_SIZE
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_n_i,
    input  logic                                                 start_i,
    input  logic                                                 stall_i,
    input  logic [$clog2(N_LP):0]                                reg_n_lp_i,
    input  logic [N_LP-1:0][NBIT_LP_IV-1:0]                      reg_lp_start_i,
    input  logic [N_LP-1:0][NBIT_LP_IV-1:0]                      reg_lp_end_i,
    input  logic [N_LP-1:0][NBIT_LP_IV-1:0]                      reg_lp_stride_i,
    output logic [HWLP_RF_SIZE-1:0][N_LP-1:0][NBIT_LP_IV-1:0]    hwlp_rf_o,
    output logic [HWLP_RF_SIZE-1:0]                              hwlp_valid_o,
    output logic [HWLP_RF_SIZE-1:0]                              end_lp_o,
    output logic [HWLP_RF_SIZE-1:0][N_LP-1:0]                    hwlp_end_condition_o,
    output logic                                                 busy_o,
    output logic                                                 done_o
);

    import mage_pkg::*;

    hwlp_ivgen_state_e state_q;
    logic              busy_q;
    logic              done_q;

    logic accept_start;
    logic advance;
    logic emit;

    logic [N_LP:0]                   carry;
    logic [N_LP-1:0][NBIT_LP_IV-1:0] iv;
    logic [N_LP-1:0][NBIT_LP_IV-1:0] tuple_iv;
    logic [N_LP-1:0]                 wrap;
    logic [N_LP-1:0]                 at_start;
    logic [N_LP-1:0]                 active;
    logic [N_LP-1:0]                 end_cond;
    logic                            cond_acc;
    logic                            final_tuple;

    logic [HWLP_RF_SIZE-1:0][N_LP-1:0][NBIT_LP_IV-1:0] rf_q;
    logic [HWLP_RF_SIZE-1:0]                           valid_q;
    logic [HWLP_RF_SIZE-1:0]                           end_lp_q;
    logic [HWLP_RF_SIZE-1:0][N_LP-1:0]                 end_cond_q;

    assign accept_start = (state_q == IDLE) && start_i;
    assign advance      = ((state_q == RUN) || (state_q == DRAIN)) && !stall_i;
    assign emit         = (state_q == RUN) && !stall_i;
    assign carry[0]     = 1'b1;

    for (genvar k = 0; k < N_LP; k++) begin : g_lp
        hwlp_iv_counter #(
            .NBIT_LP_IV (NBIT_LP_IV)
        ) u_cnt (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .load_i      (accept_start),
            .active_i    (int'(reg_n_lp_i) > k),
            .start_val_i (reg_lp_start_i[k]),
            .end_val_i   (reg_lp_end_i[k]),
            .stride_i    (reg_lp_stride_i[k]),
            .step_i      (emit),
            .carry_i     (carry[k]),
            .iv_o        (iv[k]),
            .active_o    (active[k]),
            .at_start_o  (at_start[k]),
            .wrap_o      (wrap[k]),
            .carry_o     (carry[k+1])
        );
    end

    // Inactive loops read as IV 0 with a permanently set restart flag and do
    // not hold back the final-tuple detection.
    always_comb begin
        cond_acc    = 1'b1;
        final_tuple = 1'b1;
        tuple_iv    = '0;
        end_cond    = '0;
        for (int k = 0; k < N_LP; k++) begin
            if (active[k]) begin
                cond_acc    = cond_acc & at_start[k];
                end_cond[k] = cond_acc;
                tuple_iv[k] = iv[k];
                final_tuple = final_tuple & wrap[k];
            end else begin
                end_cond[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rf_q       <= '0;
            valid_q    <= '0;
            end_lp_q   <= '0;
            end_cond_q <= '0;
        end else if (advance) begin
            for (int i = HWLP_RF_SIZE-1; i > 0; i--) begin
                rf_q[i]       <= rf_q[i-1];
                valid_q[i]    <= valid_q[i-1];
                end_lp_q[i]   <= end_lp_q[i-1];
                end_cond_q[i] <= end_cond_q[i-1];
            end
            rf_q[0]       <= emit ? tuple_iv : '0;
            valid_q[0]    <= emit;
            end_lp_q[0]   <= emit & final_tuple;
            end_cond_q[0] <= emit ? end_cond : '0;
        end
    end

    // DRAIN ends when the final tuple is shifted out of the last entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (emit && final_tuple) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (advance && end_lp_q[HWLP_RF_SIZE-1]) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hwlp_rf_o            = rf_q;
    assign hwlp_valid_o         = valid_q;
    assign end_lp_o             = end_lp_q;
    assign hwlp_end_condition_o = end_cond_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;

endmodule

// File: tb/tb_hwlp_ivgen.sv
// Directed bench for hwlp_ivgen: hand-computed tuple sequences, stall, boundary,
// ignored-start and reset-abort scenarios.
module tb_hwlp_ivgen;

    logic                  clk_i = 1'b0;
    logic                  rst_n_i;
    logic                  start_i;
    logic                  stall_i;
    logic [2:0]            reg_n_lp_i;
    logic [3:0][7:0]       reg_lp_start_i;
    logic [3:0][7:0]       reg_lp_end_i;
    logic [3:0][7:0]       reg_lp_stride_i;
    logic [7:0][3:0][7:0]  hwlp_rf_o;
    logic [7:0]            hwlp_valid_o;
    logic [7:0]            end_lp_o;
    logic [7:0][3:0]       hwlp_end_condition_o;
    logic                  busy_o;
    logic                  done_o;

    int n_cmp = 0;
    int n_err = 0;

    hwlp_ivgen dut (
        .clk_i                (clk_i),
        .rst_n_i              (rst_n_i),
        .start_i              (start_i),
        .stall_i              (stall_i),
        .reg_n_lp_i           (reg_n_lp_i),
        .reg_lp_start_i       (reg_lp_start_i),
        .reg_lp_end_i         (reg_lp_end_i),
        .reg_lp_stride_i      (reg_lp_stride_i),
        .hwlp_rf_o            (hwlp_rf_o),
        .hwlp_valid_o         (hwlp_valid_o),
        .end_lp_o             (end_lp_o),
        .hwlp_end_condition_o (hwlp_end_condition_o),
        .busy_o               (busy_o),
        .done_o               (done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic clear_cfg();
        reg_n_lp_i      = 3'd0;
        reg_lp_start_i  = '0;
        reg_lp_end_i    = '0;
        reg_lp_stride_i = '0;
    endtask

    task automatic set_loop(input int k, input logic [7:0] s, input logic [7:0] e, input logic [7:0] st);
        reg_lp_start_i[k]  = s;
        reg_lp_end_i[k]    = e;
        reg_lp_stride_i[k] = st;
    endtask

    // Leaves the bench at the negedge after the accepting posedge.
    task automatic launch();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        start_i = 1'b0;
        stall_i = 1'b0;
        clear_cfg();
        repeat (2) @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %0b expected 0", done_o); end
        n_cmp++; if (hwlp_valid_o !== 8'h00) begin n_err++; $display("[TB] FAIL reset_valid: got %0h expected 0", hwlp_valid_o); end
        n_cmp++; if (end_lp_o !== 8'h00) begin n_err++; $display("[TB] FAIL reset_end_lp: got %0h expected 0", end_lp_o); end
        n_cmp++; if (hwlp_rf_o !== '0) begin n_err++; $display("[TB] FAIL reset_rf: got %0h expected 0", hwlp_rf_o); end
        n_cmp++; if (hwlp_end_condition_o !== '0) begin n_err++; $display("[TB] FAIL reset_endcond: got %0h expected 0", hwlp_end_condition_o); end
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single_loop();
        clear_cfg();
        reg_n_lp_i = 3'd1;
        set_loop(0, 8'd0, 8'd3, 8'd1);
        launch();
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("[TB] FAIL single_busy: got %0b expected 1", busy_o); end
        n_cmp++; if (hwlp_valid_o !== 8'h00) begin n_err++; $display("[TB] FAIL single_latency: got %0h expected 0", hwlp_valid_o); end
        for (int t = 0; t < 4; t++) begin
            @(negedge clk_i);
            n_cmp++; if (hwlp_rf_o[0] !== 32'(t)) begin n_err++; $display("[TB] FAIL single_iv%0d: got %0h expected %0h", t, hwlp_rf_o[0], t); end
            n_cmp++; if (end_lp_o[0] !== (t == 3)) begin n_err++; $display("[TB] FAIL single_end_lp%0d: got %0b expected %0b", t, end_lp_o[0], t == 3); end
            n_cmp++; if (hwlp_end_condition_o[0] !== {3'b111, t == 0}) begin n_err++; $display("[TB] FAIL single_ec%0d: got %0h expected %0h", t, hwlp_end_condition_o[0], {3'b111, t == 0}); end
        end
        n_cmp++; if (hwlp_valid_o !== 8'h0F) begin n_err++; $display("[TB] FAIL single_valid_map: got %0h expected 0f", hwlp_valid_o); end
        repeat (7) @(negedge clk_i);
        n_cmp++; if (hwlp_valid_o !== 8'h80 || end_lp_o !== 8'h80) begin n_err++; $display("[TB] FAIL single_last_entry: got %0h/%0h expected 80/80", hwlp_valid_o, end_lp_o); end
        n_cmp++; if (hwlp_rf_o[7] !== 32'd3) begin n_err++; $display("[TB] FAIL single_entry7_iv: got %0h expected 3", hwlp_rf_o[7]); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("[TB] FAIL single_early_done: got %0b expected 0", done_o); end
        @(negedge clk_i);
        n_cmp++; if (done_o !== 1'b1 || busy_o !== 1'b1) begin n_err++; $display("[TB] FAIL single_done: got done=%0b busy=%0b expected 1/1", done_o, busy_o); end
        n_cmp++; if (hwlp_valid_o !== 8'h00) begin n_err++; $display("[TB] FAIL single_drained: got %0h expected 0", hwlp_valid_o); end
        @(negedge clk_i);
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("[TB] FAIL single_idle: got done=%0b busy=%0b expected 0/0", done_o, busy_o); end
    endtask

    task automatic test_two_loops();
        logic [7:0] e0 [4];
        logic [7:0] e1 [4];
        logic [3:0] ec [4];
        int         n_done;
        e0 = '{8'd0, 8'd1, 8'd0, 8'd1};
        e1 = '{8'd0, 8'd0, 8'd1, 8'd1};
        ec = '{4'hF, 4'hC, 4'hD, 4'hC};
        n_done = 0;
        clear_cfg();
        reg_n_lp_i = 3'd2;
        set_loop(0, 8'd0, 8'd1, 8'd1);
        set_loop(1, 8'd0, 8'd1, 8'd1);
        launch();
        for (int t = 0; t < 4; t++) begin
            @(negedge clk_i);
            n_cmp++; if (hwlp_rf_o[0] !== {16'd0, e1[t], e0[t]}) begin n_err++; $display("[TB] FAIL two_tuple%0d: got %0h expected %0h", t, hwlp_rf_o[0], {16'd0, e1[t], e0[t]}); end
            n_cmp++; if (hwlp_end_condition_o[0] !== ec[t]) begin n_err++; $display("[TB] FAIL two_ec%0d: got %0h expected %0h", t, hwlp_end_condition_o[0], ec[t]); end
            n_cmp++; if (end_lp_o[0] !== (t == 3)) begin n_err++; $display("[TB] FAIL two_end_lp%0d: got %0b expected %0b", t, end_lp_o[0], t == 3); end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) n_done++;
        end
        n_cmp++; if (n_done != 1) begin n_err++; $display("[TB] FAIL two_done_count: got %0d expected 1", n_done); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("[TB] FAIL two_idle: got %0b expected 0", busy_o); end
    endtask

    task automatic test_stall();
        clear_cfg();
        reg_n_lp_i = 3'd1;
        set_loop(0, 8'd0, 8'd7, 8'd1);
        launch();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk_i);
            n_cmp++; if (hwlp_rf_o[0] !== 32'(t)) begin n_err++; $display("[TB] FAIL stall_pre%0d: got %0h expected %0h", t, hwlp_rf_o[0], t); end
        end
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            n_cmp++; if (hwlp_rf_o[0] !== 32'd2 || hwlp_rf_o[1] !== 32'd1 || hwlp_valid_o !== 8'h07 || busy_o !== 1'b1) begin
                n_err++; $display("[TB] FAIL stall_frozen%0d: got iv0=%0h iv1=%0h valid=%0h busy=%0b expected 2/1/07/1", c, hwlp_rf_o[0], hwlp_rf_o[1], hwlp_valid_o, busy_o);
            end
        end
        stall_i = 1'b0;
        for (int t = 3; t < 8; t++) begin
            @(negedge clk_i);
            n_cmp++; if (hwlp_rf_o[0] !== 32'(t) || hwlp_rf_o[1] !== 32'(t - 1)) begin n_err++; $display("[TB] FAIL stall_post%0d: got %0h/%0h expected %0h/%0h", t, hwlp_rf_o[0], hwlp_rf_o[1], t, t - 1); end
        end
        n_cmp++; if (end_lp_o !== 8'h01) begin n_err++; $display("[TB] FAIL stall_end_lp: got %0h expected 01", end_lp_o); end
        repeat (7) @(negedge clk_i);
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("[TB] FAIL stall_early_done: got %0b expected 0", done_o); end
        @(negedge clk_i);
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("[TB] FAIL stall_done_timing: got %0b expected 1", done_o); end
        @(negedge clk_i);
    endtask

    task automatic test_boundary();
        logic [3:0] ec [3];
        int         n_done;
        ec = '{4'hF, 4'hC, 4'hC};
        clear_cfg();
        reg_n_lp_i = 3'd2;
        set_loop(0, 8'd0, 8'd2, 8'd0);
        set_loop(1, 8'd5, 8'd2, 8'd0);
        launch();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk_i);
            n_cmp++; if (hwlp_rf_o[0] !== {16'd0, 8'd5, 8'(t)}) begin n_err++; $display("[TB] FAIL bnd_stride0_%0d: got %0h expected %0h", t, hwlp_rf_o[0], {16'd0, 8'd5, 8'(t)}); end
            n_cmp++; if (hwlp_end_condition_o[0] !== ec[t] || end_lp_o[0] !== (t == 2)) begin n_err++; $display("[TB] FAIL bnd_flags%0d: got ec=%0h end=%0b expected %0h/%0b", t, hwlp_end_condition_o[0], end_lp_o[0], ec[t], t == 2); end
        end
        @(negedge clk_i);
        n_cmp++; if (hwlp_valid_o[0] !== 1'b0 || hwlp_rf_o[1] !== {16'd0, 8'd5, 8'd2}) begin n_err++; $display("[TB] FAIL bnd_once: got valid0=%0b e1=%0h expected 0/50002", hwlp_valid_o[0], hwlp_rf_o[1]); end
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) n_done++;
        end
        n_cmp++; if (n_done != 1) begin n_err++; $display("[TB] FAIL bnd_done_a: got %0d expected 1", n_done); end

        clear_cfg();
        reg_n_lp_i = 3'd1;
        set_loop(0, 8'd0, 8'd255, 8'd200);
        launch();
        @(negedge clk_i);
        n_cmp++; if (hwlp_rf_o[0] !== 32'd0 || end_lp_o[0] !== 1'b0) begin n_err++; $display("[TB] FAIL bnd_ovf0: got %0h end=%0b expected 0/0", hwlp_rf_o[0], end_lp_o[0]); end
        @(negedge clk_i);
        n_cmp++; if (hwlp_rf_o[0] !== 32'd200 || end_lp_o[0] !== 1'b1) begin n_err++; $display("[TB] FAIL bnd_ovf1: got %0h end=%0b expected c8/1", hwlp_rf_o[0], end_lp_o[0]); end
        @(negedge clk_i);
        n_cmp++; if (hwlp_valid_o[0] !== 1'b0) begin n_err++; $display("[TB] FAIL bnd_ovf_wrap: got %0b expected 0", hwlp_valid_o[0]); end
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) n_done++;
        end
        n_cmp++; if (n_done != 1) begin n_err++; $display("[TB] FAIL bnd_done_b: got %0d expected 1", n_done); end
    endtask

    task automatic test_repeat_start();
        clear_cfg();
        reg_n_lp_i = 3'd1;
        set_loop(0, 8'd0, 8'd2, 8'd1);
        launch();
        @(negedge clk_i);
        n_cmp++; if (hwlp_rf_o[0] !== 32'd0) begin n_err++; $display("[TB] FAIL rep_t0: got %0h expected 0", hwlp_rf_o[0]); end
        start_i = 1'b1;
        reg_lp_end_i[0] = 8'd9;
        reg_n_lp_i = 3'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        n_cmp++; if (hwlp_rf_o[0] !== 32'd1) begin n_err++; $display("[TB] FAIL rep_t1: got %0h expected 1", hwlp_rf_o[0]); end
        @(negedge clk_i);
        n_cmp++; if (hwlp_rf_o[0] !== 32'd2 || end_lp_o[0] !== 1'b1) begin n_err++; $display("[TB] FAIL rep_t2: got %0h end=%0b expected 2/1", hwlp_rf_o[0], end_lp_o[0]); end
        @(negedge clk_i);
        n_cmp++; if (hwlp_valid_o[0] !== 1'b0) begin n_err++; $display("[TB] FAIL rep_no_restart: got %0b expected 0", hwlp_valid_o[0]); end
        for (int c = 0; c < 20; c++) begin
            if (done_o === 1'b1) break;
            @(negedge clk_i);
        end
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("[TB] FAIL rep_done_timeout: got %0b expected 1", done_o); end
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0 || hwlp_valid_o !== 8'h00) begin n_err++; $display("[TB] FAIL rep_done_start%0d: got busy=%0b done=%0b valid=%0h expected 0/0/0", c, busy_o, done_o, hwlp_valid_o); end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset_drain();
        int n_done;
        clear_cfg();
        reg_n_lp_i = 3'd1;
        set_loop(0, 8'd0, 8'd1, 8'd1);
        launch();
        repeat (2) @(negedge clk_i);
        n_cmp++; if (end_lp_o[0] !== 1'b1 || hwlp_rf_o[0] !== 32'd1) begin n_err++; $display("[TB] FAIL rd_last: got %0h end=%0b expected 1/1", hwlp_rf_o[0], end_lp_o[0]); end
        @(negedge clk_i);
        n_cmp++; if (hwlp_valid_o !== 8'h06 || busy_o !== 1'b1) begin n_err++; $display("[TB] FAIL rd_draining: got %0h busy=%0b expected 06/1", hwlp_valid_o, busy_o); end
        rst_n_i = 1'b0;
        #1;
        n_cmp++; if (hwlp_valid_o !== 8'h00 || end_lp_o !== 8'h00) begin n_err++; $display("[TB] FAIL rd_async_clear: got %0h/%0h expected 0/0", hwlp_valid_o, end_lp_o); end
        n_cmp++; if (hwlp_rf_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("[TB] FAIL rd_async_state: got rf=%0h busy=%0b done=%0b expected 0", hwlp_rf_o, busy_o, done_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) n_done++;
        end
        n_cmp++; if (n_done != 0) begin n_err++; $display("[TB] FAIL rd_no_done: got %0d expected 0", n_done); end
        launch();
        @(negedge clk_i);
        n_cmp++; if (hwlp_rf_o[0] !== 32'd0 || hwlp_end_condition_o[0] !== 4'hF) begin n_err++; $display("[TB] FAIL rd_rerun0: got %0h ec=%0h expected 0/f", hwlp_rf_o[0], hwlp_end_condition_o[0]); end
        @(negedge clk_i);
        n_cmp++; if (hwlp_rf_o[0] !== 32'd1 || end_lp_o !== 8'h01) begin n_err++; $display("[TB] FAIL rd_rerun1: got %0h end=%0h expected 1/01", hwlp_rf_o[0], end_lp_o); end
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) n_done++;
        end
        n_cmp++; if (n_done != 1) begin n_err++; $display("[TB] FAIL rd_rerun_done: got %0d expected 1", n_done); end
    endtask

    initial begin
        test_reset();
        test_single_loop();
        test_two_loops();
        test_stall();
        test_boundary();
        test_repeat_start();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
